// File: rtl/rd_pkg.sv
// Shared types and k/p/g carry-symbol helpers for the recursive-doubling adder.
// A K/P/G symbol states whether a bit position kills, propagates or generates a carry.
package rd_pkg;

  typedef enum logic [1:0] {
    KPG_K = 2'b00,
    KPG_P = 2'b01,
    KPG_G = 2'b10
  } kpg_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_SUM  = 2'b10
  } state_t;

  // An upper span that propagates passes the lower span's carry status through.
  function automatic kpg_t kpg_combine(input kpg_t lower, input kpg_t upper);
    return (upper == KPG_P) ? lower : upper;
  endfunction

  function automatic kpg_t kpg_class(input logic a_bit, input logic b_bit);
    if (a_bit && b_bit) return KPG_G;
    if (!a_bit && !b_bit) return KPG_K;
    return KPG_P;
  endfunction

endpackage

// File: rtl/kpg_combine_cell.sv
// Single k/p/g combine node; purely combinational.
module kpg_combine_cell
  import rd_pkg::*;
(
  input  kpg_t lower_i,
  input  kpg_t upper_i,
  output kpg_t res_o
);

  assign res_o = kpg_combine(lower_i, upper_i);

endmodule

// File: rtl/rd_adder_seq.sv
// Sequential recursive-doubling adder: one prefix-doubling step per clock over
// the k/p/g symbol vector, then the sum is formed from the resolved carries.
module rd_adder_seq
  import rd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int STEPS  = $clog2(WIDTH) + 1;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int NSRC   = 2 ** STEP_W;

  state_t             state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  kpg_t               x_q [WIDTH+1];
  kpg_t               x_d [WIDTH+1];
  kpg_t               comb_res [WIDTH+1];
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               done_q, done_d;

  // Per position, the lower operand is x[i-d] for the current distance d=2^step;
  // positions below d pair with themselves, which combine leaves unchanged.
  for (genvar i = 0; i <= WIDTH; i++) begin : g_pos
    kpg_t src [NSRC];
    kpg_t lower_sel;

    for (genvar s = 0; s < NSRC; s++) begin : g_src
      if (s < STEPS && i >= (1 << s)) begin : g_far
        assign src[s] = x_q[i - (1 << s)];
      end else begin : g_self
        assign src[s] = x_q[i];
      end
    end

    assign lower_sel = src[step_q];

    kpg_combine_cell u_cell (
      .lower_i (lower_sel),
      .upper_i (x_q[i]),
      .res_o   (comb_res[i])
    );
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    state_d = state_q;
    step_d  = step_q;
    x_d     = x_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d[0] = cin ? KPG_G : KPG_K;
          for (int i = 0; i < WIDTH; i++) begin
            x_d[i+1] = kpg_class(a[i], b[i]);
          end
          a_d     = a;
          b_d     = b;
          step_d  = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        for (int i = 0; i <= WIDTH; i++) begin
          x_d[i] = comb_res[i];
        end
        if (step_q == STEP_W'(STEPS - 1)) begin
          step_d  = '0;
          state_d = ST_SUM;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end

      ST_SUM: begin
        // Every position now holds K or G, so x[i]==G is exactly the carry into bit i.
        for (int i = 0; i < WIDTH; i++) begin
          sum_d[i] = a_q[i] ^ b_q[i] ^ (x_q[i] == KPG_G);
        end
        cout_d  = (x_q[WIDTH] == KPG_G);
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      // NOTE: the symbol vector is reset to K so the illegal 2'b11 encoding can never appear.
      for (int i = 0; i <= WIDTH; i++) begin
        x_q[i] <= KPG_K;
      end
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
      x_q     <= x_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_rd_adder_seq.sv
// Self-checking bench: 8- and 16-bit instances compared every cycle against a
// countdown/arithmetic model, plus directed literal cases.
module tb_rd_adder_seq;
  import rd_pkg::*;

  localparam int ST8  = $clog2(8) + 1;
  localparam int ST16 = $clog2(16) + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        cin8 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        cin16 = 1'b0;

  logic        busy8, done8, cout8;
  logic [7:0]  sum8;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

  rd_adder_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  rd_adder_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;
  int done8_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: an accepted request completes STEPS+1 edges later with a+b+cin.
  int         m8_cnt = 0, m16_cnt = 0;
  logic [8:0] m8_exp = '0;
  logic [16:0] m16_exp = '0;
  logic       m8_done = 1'b0, m16_done = 1'b0;
  logic [7:0] m8_sum = '0;
  logic [15:0] m16_sum = '0;
  logic       m8_cout = 1'b0, m16_cout = 1'b0;

  always @(posedge clk) begin
    m8_done <= 1'b0;
    if (rst) begin
      m8_cnt <= 0; m8_sum <= '0; m8_cout <= 1'b0;
    end else if (m8_cnt == 0) begin
      if (start) begin
        m8_exp <= {1'b0, a8} + {1'b0, b8} + 9'(cin8);
        m8_cnt <= ST8 + 1;
      end
    end else begin
      m8_cnt <= m8_cnt - 1;
      if (m8_cnt == 1) begin
        m8_done <= 1'b1;
        {m8_cout, m8_sum} <= m8_exp;
      end
    end
  end

  always @(posedge clk) begin
    m16_done <= 1'b0;
    if (rst) begin
      m16_cnt <= 0; m16_sum <= '0; m16_cout <= 1'b0;
    end else if (m16_cnt == 0) begin
      if (start) begin
        m16_exp <= {1'b0, a16} + {1'b0, b16} + 17'(cin16);
        m16_cnt <= ST16 + 1;
      end
    end else begin
      m16_cnt <= m16_cnt - 1;
      if (m16_cnt == 1) begin
        m16_done <= 1'b1;
        {m16_cout, m16_sum} <= m16_exp;
      end
    end
  end

  always @(negedge clk) begin
    if (done8) done8_cnt++;
    if (chk_en) begin
      logic bad;
      check("done8", done8, m8_done);
      check("busy8", busy8, m8_cnt != 0);
      check("sum8", sum8, m8_sum);
      check("cout8", cout8, m8_cout);
      check("done16", done16, m16_done);
      check("busy16", busy16, m16_cnt != 0);
      check("sum16", sum16, m16_sum);
      check("cout16", cout16, m16_cout);
      bad = 1'b0;
      for (int i = 0; i <= 8; i++) if (dut8.x_q[i] == 2'b11) bad = 1'b1;
      for (int i = 0; i <= 16; i++) if (dut16.x_q[i] == 2'b11) bad = 1'b1;
      check("sym_legal", bad, 1'b0);
    end
  end

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] es, input logic ec, input string tag);
    bit found = 1'b0;
    @(posedge clk); #1;
    a8 = a; b8 = b; cin8 = c;
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done8 && !found) begin
        found = 1'b1;
        check({tag, "_lat"}, k, 6);
        check({tag, "_sum"}, sum8, es);
        check({tag, "_cout"}, cout8, ec);
        check({tag, "_model"}, {m8_cout, m8_sum}, {ec, es});
      end
    end
    if (!found) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic op(input logic [7:0] x8, input logic [7:0] y8, input logic c8,
                    input logic [15:0] x16, input logic [15:0] y16, input logic c16);
    bit idle = 1'b0;
    @(posedge clk); #1;
    a8 = x8; b8 = y8; cin8 = c8; a16 = x16; b16 = y16; cin16 = c16;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 20 && !idle; k++) begin
      @(negedge clk);
      if (!busy8 && !busy16) idle = 1'b1;
    end
    if (!idle) check("op_timeout", 0, 1);
  endtask

  initial begin
    int base;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_sum", {cout8, sum8}, 9'h000);
    @(posedge clk); #1;
    rst = 1'b0;

    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff_plus_1");
    run8(8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, "allp_cin1");
    run8(8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, "allp_cin0");
    run8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "zero_cin1");
    check("x8_top_k", dut8.x_q[8], KPG_K);

    // Starts during an operation are ignored.
    @(posedge clk); #1;
    base = done8_cnt;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) @(negedge clk);
    @(posedge clk);
    check("ign_done_cnt", done8_cnt - base, 1);
    check("ign_sum", {cout8, sum8}, 9'h046);

    // Reset during RUN step 2 abandons the operation.
    #1;
    a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy8, 1'b0);
    check("mid_rst_done", done8, 1'b0);
    check("mid_rst_res", {cout8, sum8}, 9'h000);
    run8(8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, "after_rst");

    // Back-to-back with start held high; operands change every cycle.
    @(posedge clk); #1;
    base = done8_cnt;
    start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge clk);
    check("b2b_done_cnt", done8_cnt - base, 4);

    op(8'h80, 8'h80, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
    check("w16_sum", {cout16, sum16}, 17'h10000);
    check("w8_sum", {cout8, sum8}, 9'h100);

    for (int n = 0; n < 1000; n++) begin
      logic [7:0]  x8;
      logic [15:0] x16;
      x8 = 8'($urandom);
      x16 = 16'($urandom);
      if (n % 4 == 0) op(x8, ~x8, 1'($urandom), x16, ~x16, 1'($urandom));
      else op(x8, 8'($urandom), 1'($urandom), x16, 16'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
